// File: rtl/router_pkt_ctrl.sv
// rtl/router_pkt_ctrl.sv - packet router control FSM with per-FIFO idle flush
//
// Purpose: accepts a byte stream {header, payload..., parity}. The header is
//          {payload_len[7:2], addr[1:0]}. Packets are steered to one of three
//          output FIFOs, with backpressure and parity checking.
//          Packets to addr 3 are dropped. An output FIFO that holds data but is
//          not read for 30 consecutive cycles gets a one-cycle soft_reset.
// Optional: ROUTER_PARITY_CHECK_EN builds the running-parity checker that
//           drives err. Without it, err is tied low.
// Ports:
//   clock, reset        - system clock; asynchronous active-high reset
//   pkt_valid, data_in  - source byte stream; pkt_valid is low on the parity byte
//   fifo_full/empty     - per-FIFO status flags
//   read_enb            - per-FIFO read strobes from the output side
//   write_enb           - one-hot FIFO write strobe
//   lfd_state           - marks the header write
//   fifo_data           - byte presented to the FIFOs
//   busy                - source must hold data_in/pkt_valid
//   soft_reset          - per-FIFO flush pulse
//   err                 - parity mismatch on the last packet
module router_pkt_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic [7:0] fifo_data,
    output logic       busy,
    output logic [2:0] soft_reset,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FULL_HOLD,
        LOAD_AFTER_FULL,
        CHECK_PARITY,
        DROP
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_q;
    logic [7:0] hdr_q;
    logic [7:0] hold_q;
    logic       hold_par_q;    // held byte was the parity byte
    logic [4:0] idle_cnt [3];
    logic       we;
    logic       cap_hdr;
    logic       cap_hold;
    logic       sr_addr;
    logic       full_addr;

    assign sr_addr   = soft_reset[addr_q];
    assign full_addr = fifo_full[addr_q];

    // Idle detection is combinational so that the pulse lands in the 30th
    // idle cycle itself and can abort the packet in that same cycle.
    always_comb begin
        soft_reset = 3'b000;
        for (int i = 0; i < 3; i++) begin
            soft_reset[i] = !fifo_empty[i] && !read_enb[i] && (idle_cnt[i] == 5'd29);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                idle_cnt[i] <= 5'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (fifo_empty[i] || read_enb[i] || soft_reset[i]) begin
                    idle_cnt[i] <= 5'd0;
                end else begin
                    idle_cnt[i] <= idle_cnt[i] + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= 2'd0;
            hdr_q      <= 8'd0;
            hold_q     <= 8'd0;
            hold_par_q <= 1'b0;
        end else begin
            state <= next_state;
            if (cap_hdr) begin
                addr_q <= data_in[1:0];
                hdr_q  <= data_in;
            end
            if (cap_hold) begin
                hold_q     <= data_in;
                hold_par_q <= !pkt_valid;
            end
        end
    end

    always_comb begin
        next_state = state;
        we         = 1'b0;
        lfd_state  = 1'b0;
        busy       = 1'b0;
        fifo_data  = 8'd0;
        cap_hdr    = 1'b0;
        cap_hold   = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_valid) begin
                    if (data_in[1:0] == 2'd3) begin
                        next_state = DROP;
                    end else begin
                        cap_hdr    = 1'b1;
                        next_state = fifo_empty[data_in[1:0]] ? LOAD_FIRST : WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (fifo_empty[addr_q]) begin
                    next_state = LOAD_FIRST;
                end
            end
            LOAD_FIRST: begin
                busy = 1'b1;
                if (sr_addr) begin
                    next_state = DROP;
                end else begin
                    we         = 1'b1;
                    lfd_state  = 1'b1;
                    fifo_data  = hdr_q;
                    next_state = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                fifo_data = data_in;
                if (sr_addr) begin
                    next_state = DROP;
                end else if (full_addr) begin
                    // Byte is consumed into the hold register, so busy stays low.
                    cap_hold   = 1'b1;
                    next_state = FULL_HOLD;
                end else begin
                    we = 1'b1;
                    if (!pkt_valid) begin
                        next_state = CHECK_PARITY;
                    end
                end
            end
            FULL_HOLD: begin
                busy = 1'b1;
                if (sr_addr) begin
                    next_state = DROP;
                end else if (!full_addr) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                busy      = 1'b1;
                fifo_data = hold_q;
                if (sr_addr) begin
                    next_state = DROP;
                end else begin
                    we         = 1'b1;
                    next_state = hold_par_q ? CHECK_PARITY : LOAD_DATA;
                end
            end
            CHECK_PARITY: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            DROP: begin
                if (!pkt_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        write_enb = 3'b000;
        if (we) begin
            case (addr_q)
                2'd0:    write_enb = 3'b001;
                2'd1:    write_enb = 3'b010;
                2'd2:    write_enb = 3'b100;
                default: write_enb = 3'b000;
            endcase
        end
    end

`ifdef ROUTER_PARITY_CHECK_EN
    logic [7:0] run_par;
    logic [7:0] rx_par;
    logic       err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_par <= 8'd0;
            rx_par  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (cap_hdr) begin
                run_par <= data_in;
                err_q   <= 1'b0;
            end else if (state == LOAD_DATA && !sr_addr) begin
                // Every byte consumed in LOAD_DATA counts, even one diverted to hold.
                if (pkt_valid) begin
                    run_par <= run_par ^ data_in;
                end else begin
                    rx_par <= data_in;
                end
            end
            if (state == CHECK_PARITY) begin
                err_q <= (rx_par != run_par);
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// tb/tb_router_pkt_ctrl.sv - scoreboard testbench for router_pkt_ctrl
module tb_router_pkt_ctrl;

    logic       clock;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic [7:0] fifo_data;
    logic       busy;
    logic [2:0] soft_reset;
    logic       err;

    typedef struct {
        logic [1:0] port;
        logic [7:0] data;
        logic       lfd;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  wr_count = 0;
    int  lfd_count = 0;
    logic busy_in_full;

    router_pkt_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .soft_reset (soft_reset),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every write must match the next scoreboard entry.
    always @(negedge clock) begin
        if (write_enb != 3'b000) begin
            wr_t e;
            wr_count++;
            if (lfd_state) lfd_count++;
            check("we_onehot", {31'd0, $onehot(write_enb)}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {29'd0, write_enb}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", {24'd0, fifo_data}, {24'd0, e.data});
                check("wr_port", {29'd0, write_enb}, {29'd0, 3'b001 << e.port});
                check("wr_lfd", {31'd0, lfd_state}, {31'd0, e.lfd});
            end
        end
    end

    // Sends one packet honouring busy. full_at: byte index at which fifo_full
    // for the packet's port is raised for 3 cycles. rst_at: byte index at
    // which reset is applied mid-packet (-1 disables either).
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] corrupt,
                            input int full_at, input int rst_at);
        logic [7:0] b[$];
        logic [7:0] par;
        int npay;
        int i;
        int guard;
        int full_left;
        logic consumed;
        wr_t e;
        npay = int'(hdr[7:2]);
        par = hdr;
        b.push_back(hdr);
        for (int k = 0; k < npay; k++) begin
            logic [7:0] p;
            p = 8'($urandom_range(0, 255));
            par ^= p;
            b.push_back(p);
        end
        b.push_back(par ^ corrupt);
        if (hdr[1:0] != 2'd3) begin
            for (int k = 0; k < b.size(); k++) begin
                e.port = hdr[1:0];
                e.data = b[k];
                e.lfd  = (k == 0);
                exp_q.push_back(e);
            end
        end
        i = 0;
        guard = 0;
        full_left = 0;
        busy_in_full = 1'b0;
        while (i < b.size() && guard < 300) begin
            if (i == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_write_enb", {29'd0, write_enb}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_lfd", {31'd0, lfd_state}, 32'd0);
                check("rst_fifo_data", {24'd0, fifo_data}, 32'd0);
                exp_q.delete();
                @(posedge clock);
                #1;
                reset = 1'b0;
                break;
            end
            data_in = b[i];
            pkt_valid = (i < b.size() - 1);
            if (i == full_at && full_left == 0) begin
                fifo_full[hdr[1:0]] = 1'b1;
                full_left = 3;
            end
            @(negedge clock);
            consumed = !busy;
            if (full_left > 0 && i > full_at && busy) busy_in_full = 1'b1;
            @(posedge clock);
            #1;
            if (consumed) i++;
            if (full_left > 0) begin
                full_left--;
                if (full_left == 0) fifo_full[hdr[1:0]] = 1'b0;
            end
            guard++;
        end
        if (rst_at < 0) check("src_timeout", i, b.size());
        pkt_valid = 1'b0;
        data_in = 8'd0;
    endtask

    initial begin
        int w0;
        int l0;
        int pulses;
        int pulse_at;
        logic exp_err;
        reset = 1'b1;
        pkt_valid = 1'b0;
        data_in = 8'd0;
        fifo_full = 3'b000;
        fifo_empty = 3'b111;
        read_enb = 3'b000;
        #2;
        check("reset_write_enb", {29'd0, write_enb}, 32'd0);
        check("reset_lfd", {31'd0, lfd_state}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_soft_reset", {29'd0, soft_reset}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_fifo_data", {24'd0, fifo_data}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Nominal packet: header 0x25, 9 payload bytes, good parity.
        w0 = wr_count; l0 = lfd_count;
        send_pkt(8'h25, 8'h00, -1, -1);
        repeat (2) @(posedge clock);
        #1;
        check("p1_writes", wr_count - w0, 11);
        check("p1_lfd", lfd_count - l0, 1);
        check("p1_err", {31'd0, err}, 32'd0);

        // Corrupted parity.
`ifdef ROUTER_PARITY_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        w0 = wr_count;
        send_pkt(8'h25, 8'h01, -1, -1);
        repeat (2) @(posedge clock);
        #1;
        check("p2_writes", wr_count - w0, 11);
        check("p2_err", {31'd0, err}, {31'd0, exp_err});

        // fifo_full on payload 4 for 3 cycles.
        w0 = wr_count;
        send_pkt(8'h25, 8'h00, 4, -1);
        repeat (2) @(posedge clock);
        #1;
        check("p3_writes", wr_count - w0, 11);
        check("p3_busy_in_full", {31'd0, busy_in_full}, 32'd1);
        check("p3_err", {31'd0, err}, 32'd0);

        // Address 3 is dropped.
        w0 = wr_count;
        send_pkt(8'h0B, 8'h00, -1, -1);
        repeat (3) @(posedge clock);
        #1;
        check("drop_writes", wr_count - w0, 0);

        // Destination not empty: wait before loading.
        fifo_empty[0] = 1'b0;
        fork
            begin
                repeat (5) @(posedge clock);
                #1;
                fifo_empty[0] = 1'b1;
            end
        join_none
        w0 = wr_count;
        send_pkt(8'h08, 8'h00, -1, -1);
        repeat (2) @(posedge clock);
        #1;
        check("wait_writes", wr_count - w0, 4);

        // Idle counter on FIFO 2.
        fifo_empty[2] = 1'b0;
        pulses = 0;
        pulse_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (soft_reset[2]) begin
                pulses++;
                pulse_at = k;
            end
            @(posedge clock);
            #1;
        end
        fifo_empty[2] = 1'b1;
        check("sr_pulses", pulses, 1);
        check("sr_cycle", pulse_at, 30);

        // Reset mid-payload, then a normal packet.
        send_pkt(8'h25, 8'h00, -1, 5);
        w0 = wr_count;
        repeat (4) @(posedge clock);
        #1;
        check("post_rst_quiet", wr_count - w0, 0);
        w0 = wr_count;
        send_pkt(8'h16, 8'h00, -1, -1);
        repeat (2) @(posedge clock);
        #1;
        check("post_rst_writes", wr_count - w0, 7);
        check("post_rst_err", {31'd0, err}, 32'd0);
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/router_pkt_ctrl.md
ROUTER_PKT_CTRL -- requirements
Module: router_pkt_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: pkt_valid  input  1  source marks header/payload bytes; low on the parity byte.
REQ-004 SHALL have port: data_in  input  8  source byte; header = {payload_len[7:2], addr[1:0]}.
REQ-005 SHALL have port: fifo_full  input  3  full flag per output FIFO.
REQ-006 SHALL have port: fifo_empty  input  3  empty flag per output FIFO.
REQ-007 SHALL have port: read_enb  input  3  per-FIFO read strobe from the output side.
REQ-008 SHALL have port: write_enb  output  3  one-hot FIFO write strobe.
REQ-009 SHALL have port: lfd_state  output  1  high only in the cycle the header is written.
REQ-010 SHALL have port: fifo_data  output  8  byte presented to the FIFOs.
REQ-011 SHALL have port: busy  output  1  source must hold data_in and pkt_valid.
REQ-012 SHALL have port: soft_reset  output  3  one-cycle per-FIFO flush pulse.
REQ-013 SHALL have port: err  output  1  parity mismatch on last packet.

Function
REQ-014 SHALL implement states IDLE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, FULL_HOLD, LOAD_AFTER_FULL, CHECK_PARITY, DROP.
REQ-015 IDLE: on pkt_valid=1 with addr!=3, latch addr and header; go WAIT_EMPTY if fifo_empty[addr]=0, else LOAD_FIRST; addr=3 goes DROP.
REQ-016 WAIT_EMPTY: busy=1, no writes; go LOAD_FIRST in the cycle after fifo_empty[addr]=1 is sampled.
REQ-017 LOAD_FIRST: write_enb[addr]=1, lfd_state=1, fifo_data=latched header, busy=1; next LOAD_DATA.
REQ-018 LOAD_DATA: busy=0, write_enb[addr]=1, fifo_data=data_in; pkt_valid=0 means parity byte, go CHECK_PARITY.
REQ-019 LOAD_DATA with fifo_full[addr]=1: suppress write, capture data_in into hold register, go FULL_HOLD.
REQ-020 FULL_HOLD: busy=1, no write; go LOAD_AFTER_FULL when fifo_full[addr]=0.
REQ-021 LOAD_AFTER_FULL: write hold register, busy=1; then LOAD_DATA (held byte was payload) or CHECK_PARITY (held byte was parity).
REQ-022 CHECK_PARITY: busy=1, no write; update err; next IDLE.
REQ-023 DROP: no writes, busy=0; return IDLE when pkt_valid=0.
REQ-024 write_enb SHALL be one-hot or zero, never multi-hot.
REQ-025 Running parity SHALL be 8-bit XOR of header and all payload bytes; cleared on header accept.
REQ-026 Per FIFO i, a 5-bit idle counter SHALL increment when fifo_empty[i]=0 and read_enb[i]=0, else clear.
REQ-027 On the 30th consecutive idle cycle soft_reset[i] SHALL pulse one cycle and the counter clears.
REQ-028 soft_reset[addr] while in LOAD_*/FULL_HOLD SHALL abort to DROP (remainder of packet discarded).

Reset
REQ-029 reset=1 SHALL asynchronously force state IDLE, counters 0, parity 0, hold/header regs 0.
REQ-030 During and after reset: write_enb=0, lfd_state=0, busy=0, soft_reset=0, err=0, fifo_data=0.
REQ-031 Reset mid-packet SHALL discard the packet with no further writes.

Configuration
REQ-032 Macro ROUTER_PARITY_CHECK_EN defined: err=1 after CHECK_PARITY if received parity != running parity, held until next header accept.
REQ-033 Macro undefined: parity logic omitted, err tied 0, CHECK_PARITY still traversed (one busy cycle).

Verification
REQ-034 Header 0x25 (len 9, addr 1), 9 payload, parity correct, all FIFOs empty -> 11 write_enb[1] pulses, lfd_state on first only, err=0.
REQ-035 Same packet with parity XOR 0x01, macro defined -> err=1 after CHECK_PARITY; macro undefined -> err=0.
REQ-036 fifo_full[1] raised on payload 4 for 3 cycles -> busy=1, byte 4 written once after full clears, total 11 writes, no loss/duplicate.
REQ-037 Header 0x0B (addr 3) -> DROP, write_enb stays 0 until pkt_valid falls.
REQ-038 FIFO 2 non-empty, read_enb[2]=0 for 30 cycles -> single soft_reset[2] pulse on cycle 30.
REQ-039 reset asserted mid-payload -> outputs zero same cycle, next packet accepted normally.
